i2c_master_ctrl: RTL

Single-byte I2C master controller between the APB-facing `APB_I2C_Bus` (master modport) and the I2C `SDA`/`SCL` pins. It takes one write or read request per transaction, then drives the full bus sequence: START, 7-bit address plus R/W, ACK check, one data byte, ACK/NACK, STOP. It reports completion, read data and slave-NACK errors back to the APB side. The bus is open-drain, so the controller only ever pulls lines low or releases them.

---
 rtl/i2c_master_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK/NACK, STOP.
// Optional feature macro I2C_CLK_STRETCH_EN enables slave clock stretching.
// Ports: clk, reset (sync, active-high); request side ce/wren/rden/addr/wdata;
//   status rdata/error/busy/done; open-drain pins scl_oe/sda_oe with senses
//   scl_i/sda_i (already synchronized at the pad level).
module i2c_master_ctrl #(
    parameter int CLK_DIV = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       wren,
    input  logic       rden,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       error,
    output logic       busy,
    output logic       done,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       scl_i,
    input  logic       sda_i
);

    typedef enum logic [2:0] {
        IDLE, START, ADDR, AACK, WBYTE, RBYTE, DACK, STOP
    } state_t;

    localparam logic [9:0] QMAX = 10'(CLK_DIV - 1);

    state_t     state, state_n;
    logic [1:0] quarter, quarter_n;
    logic [9:0] qcnt, qcnt_n;
    logic [2:0] bitc, bitc_n;
    logic [6:0] addr_q;
    logic [7:0] wdata_q;
    logic       rw;
    logic       scl_n, sda_n;
    logic       hold;
    logic       accept, illegal;
    logic       tick, sample, bit_end;
    logic [7:0] abyte;

    assign accept  = ce & (wren ^ rden);
    assign illegal = ce & wren & rden;
    assign tick    = (qcnt == QMAX) && !hold;
    assign sample  = tick && (quarter == 2'd2);
    assign bit_end = tick && (quarter == 2'd3);
    assign abyte   = {addr_q, rw};

`ifdef I2C_CLK_STRETCH_EN
    // Freeze at the start of each released-SCL phase until the pin
    // actually reads high, so a slave can hold the low phase open.
    assign hold = (state != IDLE) && (qcnt == 10'd0) && !scl_i &&
                  ((quarter == 2'd2) ||
                   ((state == STOP) && (quarter == 2'd1)));
`else
    assign hold = 1'b0;
`endif

    logic unused_ok;
    assign unused_ok = ^{scl_i, addr[7]};

    always_comb begin
        state_n   = state;
        quarter_n = quarter;
        qcnt_n    = qcnt;
        bitc_n    = bitc;
        if (state == IDLE) begin
            if (accept) begin
                state_n   = START;
                quarter_n = 2'd0;
                qcnt_n    = 10'd0;
                bitc_n    = 3'd0;
            end
        end else if (!hold) begin
            if (qcnt == QMAX) begin
                qcnt_n    = 10'd0;
                quarter_n = quarter + 2'd1;
                if (quarter == 2'd3) begin
                    bitc_n = bitc + 3'd1;
                    case (state)
                        START: begin
                            state_n = ADDR;
                            bitc_n  = 3'd0;
                        end
                        ADDR: if (bitc == 3'd7) state_n = AACK;
                        AACK: begin
                            // error here can only come from the address NACK
                            if (error)   state_n = STOP;
                            else if (rw) state_n = RBYTE;
                            else         state_n = WBYTE;
                            bitc_n = 3'd0;
                        end
                        WBYTE, RBYTE: if (bitc == 3'd7) state_n = DACK;
                        DACK:    state_n = STOP;
                        STOP:    state_n = IDLE;
                        default: state_n = IDLE;
                    endcase
                end
            end else begin
                qcnt_n = qcnt + 10'd1;
            end
        end
    end

    // Line levels are derived from the next phase so the registered
    // outputs line up exactly with the phase they belong to.
    always_comb begin
        scl_n = 1'b0;
        sda_n = 1'b0;
        case (state_n)
            START: begin
                scl_n = (quarter_n == 2'd3);
                sda_n = quarter_n[1];
            end
            ADDR: begin
                scl_n = !quarter_n[1];
                sda_n = !abyte[~bitc_n];
            end
            WBYTE: begin
                scl_n = !quarter_n[1];
                sda_n = !wdata_q[~bitc_n];
            end
            AACK, RBYTE, DACK: scl_n = !quarter_n[1];
            STOP: begin
                scl_n = (quarter_n == 2'd0);
                sda_n = (quarter_n != 2'd3);
            end
            default: begin
                scl_n = 1'b0;
                sda_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            quarter <= 2'd0;
            qcnt    <= 10'd0;
            bitc    <= 3'd0;
            addr_q  <= 7'd0;
            wdata_q <= 8'd0;
            rw      <= 1'b0;
            rdata   <= 8'h00;
            error   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            scl_oe  <= 1'b0;
            sda_oe  <= 1'b0;
        end else begin
            state   <= state_n;
            quarter <= quarter_n;
            qcnt    <= qcnt_n;
            bitc    <= bitc_n;
            scl_oe  <= scl_n;
            sda_oe  <= sda_n;
            done    <= 1'b0;
            if (state == IDLE) begin
                if (illegal) begin
                    error <= 1'b1;
                    done  <= 1'b1;
                end else if (accept) begin
                    addr_q  <= addr[6:0];
                    wdata_q <= wdata;
                    rw      <= rden;
                    error   <= 1'b0;
                    busy    <= 1'b1;
                end
            end
            if (sample) begin
                if ((state == AACK) && sda_i)
                    error <= 1'b1;
                if ((state == DACK) && !rw && sda_i)
                    error <= 1'b1;
                if (state == RBYTE)
                    rdata <= {rdata[6:0], sda_i};
            end
            if ((state == STOP) && bit_end) begin
                done <= 1'b1;
                busy <= 1'b0;
            end
        end
    end

endmodule
